liteeth_sram_fifo_ctrl: RTL and testbench

- Packet-aware FIFO controller that runs one liteeth_1rw1r_32w384d_8_sram instance as a circular frame buffer in the MAC RX path.
- Port 0 of the SRAM is the write port. Port 1 is the read port.
- Words of a frame are held back until the frame's last word is committed. Aborted or overflowed frames are rewound.
- The read side is a valid/ready stream with a 2-entry output buffer that hides the SRAM's 1-cycle read latency.

---
 rtl/liteeth_sram_fifo_pkg.sv | 22 ++
 rtl/liteeth_sram_fifo_obuf.sv | 56 +++++
 rtl/liteeth_sram_fifo_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_liteeth_sram_fifo_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/liteeth_sram_fifo_pkg.sv
// Shared types and helpers for the packet-aware SRAM FIFO controller.
package liteeth_sram_fifo_pkg;

    localparam int unsigned DEPTH_DEFAULT = 384;
    localparam int unsigned PTR_MAX_W     = 16;

    // Write-side frame state: no open frame, frame being stored, frame being dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    // Advance a circular pointer, wrapping depth-1 back to 0 (depth need not be 2^n)
    function automatic logic [PTR_MAX_W-1:0] ptr_inc(
        input logic [PTR_MAX_W-1:0] ptr,
        input logic [PTR_MAX_W-1:0] depth
    );
        return (ptr == depth - 16'd1) ? '0 : ptr + 16'd1;
    endfunction

endpackage

// File: rtl/liteeth_sram_fifo_obuf.sv
// Two-entry output skid buffer that absorbs the SRAM's one-cycle read latency.
module liteeth_sram_fifo_obuf #(
    parameter int DATA_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        buf_cnt
);

    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign buf_cnt   = cnt_q;

    // One storage register per entry, written when the write selector points at it
    for (genvar gi = 0; gi < 2; gi++) begin : g_ent
        logic [DATA_W-1:0] ent_q;
        always_ff @(posedge sys_clk) begin
            if (push && (wr_sel_q == 1'(gi))) begin
                ent_q <= push_data;
            end
        end
    end

    assign out_data = rd_sel_q ? g_ent[1].ent_q : g_ent[0].ent_q;

    // Occupancy and selector updates; push and pop may coincide
    always_comb begin
        wr_sel_d = wr_sel_q ^ push;
        rd_sel_d = rd_sel_q ^ pop;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
    end

    // Control state registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Packet-aware circular frame buffer around a 1RW+1R SRAM for the MAC RX path.
// Frames become readable only once their last word is committed; aborted or
// overflowing frames are rewound. Optional statistics counters are enabled
// with the LITEETH_SRAM_FIFO_STATS_EN macro.
module liteeth_sram_fifo_ctrl
    import liteeth_sram_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 9
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sink_valid,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_last,
    input  logic              sink_abort,
    output logic              source_valid,
    input  logic              source_ready,
    output logic [DATA_W-1:0] source_data,
    output logic              ovf_drop,
    output logic [ADDR_W:0]   level,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [3:0]        sram_wmask0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [DATA_W-1:0] sram_din0,
    output logic              sram_csb1,
    output logic [ADDR_W-1:0] sram_addr1,
    input  logic [DATA_W-1:0] sram_dout1
`ifdef LITEETH_SRAM_FIFO_STATS_EN
    ,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_drops
`endif
);

    localparam int CNT_W = ADDR_W + 1;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]  stored_q, stored_d;
    logic              inflight_q, inflight_d;

    logic [CNT_W-1:0]  space;
    logic [CNT_W-1:0]  commit_add;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic [ADDR_W-1:0] rd_ptr_inc;
    logic              in_drop;
    logic              wr_en;
    logic              ovf_c;
    logic              rd_issue;
    logic              pop;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;

    assign space      = CNT_W'(DEPTH) - stored_q - pending_q;
    assign in_drop    = (state_q == DROP);
    assign wr_en      = !sys_rst && sink_valid && !in_drop && (space != '0) && !sink_abort;
    assign wr_ptr_inc = ADDR_W'(ptr_inc(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(DEPTH)));
    assign rd_ptr_inc = ADDR_W'(ptr_inc(PTR_MAX_W'(rd_ptr_q), PTR_MAX_W'(DEPTH)));

    // Write port is a straight pass-through of the current write pointer and data
    assign sram_wmask0 = 4'hF;
    assign sram_addr0  = wr_ptr_q;
    assign sram_din0   = sink_data;
    assign sram_csb0   = !wr_en;
    assign sram_web0   = !wr_en;
    assign ovf_drop    = ovf_c && !sys_rst;

    // Write FSM: accept, commit, abort-rewind and overflow-drop handling
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        pending_d    = pending_q;
        commit_add   = '0;
        ovf_c        = 1'b0;
        if (sink_abort) begin
            // Abort beats last; a dropped frame also ends here
            wr_ptr_d  = commit_ptr_q;
            pending_d = '0;
            if (in_drop) begin
                ovf_c   = 1'b1;
                state_d = IDLE;
            end
        end else if (in_drop) begin
            if (sink_valid && sink_last) begin
                ovf_c   = 1'b1;
                state_d = IDLE;
            end
        end else if (sink_valid && (space == '0)) begin
            // No room: rewind and swallow the rest of this frame
            wr_ptr_d  = commit_ptr_q;
            pending_d = '0;
            if (sink_last) begin
                ovf_c = 1'b1;
            end else begin
                state_d = DROP;
            end
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_inc;
            if (sink_last) begin
                commit_ptr_d = wr_ptr_inc;
                commit_add   = pending_q + CNT_W'(1);
                pending_d    = '0;
            end else begin
                pending_d = pending_q + CNT_W'(1);
            end
        end
        if (state_d != DROP) begin
            state_d = (pending_d != '0) ? FRAME : IDLE;
        end
    end

    // Read issue: keep the skid buffer plus the in-flight read within two words
    always_comb begin
        occ        = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
        rd_issue   = !sys_rst && (stored_q != '0) && (occ < 3'd2);
        rd_ptr_d   = rd_issue ? rd_ptr_inc : rd_ptr_q;
        inflight_d = rd_issue;
        stored_d   = stored_q + commit_add - CNT_W'(rd_issue);
    end

    assign sram_csb1  = !rd_issue;
    assign sram_addr1 = rd_ptr_q;

    // Pointer, counter and FSM state registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            stored_q     <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pending_q    <= pending_d;
            stored_q     <= stored_d;
            inflight_q   <= inflight_d;
        end
    end

    liteeth_sram_fifo_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (inflight_q),
        .push_data (sram_dout1),
        .out_valid (source_valid),
        .out_ready (source_ready),
        .out_data  (source_data),
        .buf_cnt   (buf_cnt)
    );

    assign pop   = source_valid && source_ready;
    assign level = stored_q + CNT_W'(inflight_q) + CNT_W'(buf_cnt);

`ifdef LITEETH_SRAM_FIFO_STATS_EN
    logic [15:0] stat_frames_q, stat_frames_d;
    logic [15:0] stat_drops_q, stat_drops_d;
    logic        commit_ev;
    logic        drop_ev;

    assign commit_ev = wr_en && sink_last;
    assign drop_ev   = (sink_abort && (pending_q != '0)) || ovf_drop;

    // Saturating frame and drop counters
    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_drops_d  = stat_drops_q;
        if (commit_ev && (stat_frames_q != 16'hFFFF)) begin
            stat_frames_d = stat_frames_q + 16'd1;
        end
        if (drop_ev && (stat_drops_q != 16'hFFFF)) begin
            stat_drops_d = stat_drops_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_frames_q <= '0;
            stat_drops_q  <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_drops_q  <= stat_drops_d;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Directed self-checking bench for liteeth_sram_fifo_ctrl with a behavioural SRAM.
module tb_liteeth_sram_fifo_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 384;
    localparam int ADDR_W = 9;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              sink_valid = 1'b0;
    logic [DATA_W-1:0] sink_data = '0;
    logic              sink_last = 1'b0;
    logic              sink_abort = 1'b0;
    logic              source_valid;
    logic              source_ready = 1'b0;
    logic [DATA_W-1:0] source_data;
    logic              ovf_drop;
    logic [ADDR_W:0]   level;
    logic              sram_csb0, sram_web0, sram_csb1;
    logic [3:0]        sram_wmask0;
    logic [ADDR_W-1:0] sram_addr0, sram_addr1;
    logic [DATA_W-1:0] sram_din0;
    logic [DATA_W-1:0] sram_dout1;

    always #5 sys_clk = ~sys_clk;

    liteeth_sram_fifo_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .sink_valid   (sink_valid),
        .sink_data    (sink_data),
        .sink_last    (sink_last),
        .sink_abort   (sink_abort),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .ovf_drop     (ovf_drop),
        .level        (level),
        .sram_csb0    (sram_csb0),
        .sram_web0    (sram_web0),
        .sram_wmask0  (sram_wmask0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .sram_csb1    (sram_csb1),
        .sram_addr1   (sram_addr1),
        .sram_dout1   (sram_dout1)
    );

    // Behavioural 1RW+1R SRAM with one-cycle registered read
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge sys_clk) begin
        if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic a);
        @(posedge sys_clk);
        #1;
        sink_valid = v;
        sink_data  = d;
        sink_last  = l;
        sink_abort = a;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Pull n words (mode 0: ready high, 1: toggling, 2: random) and compare against exp_q
    task automatic drain(input int n, input int mode);
        int got = 0;
        int cyc = 0;
        logic [DATA_W-1:0] e;
        while (got < n && cyc < n * 4 + 20) begin
            @(posedge sys_clk);
            #1;
            sink_valid = 1'b0;
            sink_last  = 1'b0;
            sink_abort = 1'b0;
            if (mode == 0) source_ready = 1'b1;
            else if (mode == 1) source_ready = ~source_ready;
            else source_ready = 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (source_valid && source_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                chk("drain_data", 64'(source_data), 64'(e));
                got++;
            end
        end
        chk("drain_count", 64'(got), 64'(n));
        source_ready = 1'b1;
        repeat (3) idle();
        chk("drain_empty_valid", 64'(source_valid), 64'd0);
        chk("drain_empty_level", 64'(level), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lvl_t [7];
        int val_t [7];
        logic [DATA_W-1:0] dat_t [7];
        int i_w;
        int got;
        int cyc;
        logic wr_now;
        logic [DATA_W-1:0] e;

        // ---- reset: write attempts must be blocked while held
        sink_valid = 1'b1;
        sink_data  = 32'hDEAD;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_valid", 64'(source_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_csb0", 64'(sram_csb0), 64'd1);
        chk("rst_web0", 64'(sram_web0), 64'd1);
        chk("rst_csb1", 64'(sram_csb1), 64'd1);
        chk("rst_ovf", 64'(ovf_drop), 64'd0);
        chk("rst_wmask", 64'(sram_wmask0), 64'hF);
        sys_rst    = 1'b0;
        sink_valid = 1'b0;
        $display("reset done");

        // ---- commit and pass-through with 3-cycle latency
        source_ready = 1'b1;
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        chk("t1_csb0", 64'(sram_csb0), 64'd0);
        chk("t1_addr0", 64'(sram_addr0), 64'd0);
        chk("t1_din0", 64'(sram_din0), 64'h11);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 1'b1, 1'b0);
        lvl_t = '{4, 4, 4, 3, 2, 1, 0};
        val_t = '{0, 0, 1, 1, 1, 1, 0};
        dat_t = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0};
        for (int k = 0; k < 7; k++) begin
            idle();
            if (k == 0) begin
                chk("t1_csb1", 64'(sram_csb1), 64'd0);
                chk("t1_addr1", 64'(sram_addr1), 64'd0);
            end
            chk("t1_level", 64'(level), 64'(lvl_t[k]));
            chk("t1_valid", 64'(source_valid), 64'(val_t[k]));
            if (val_t[k] == 1) chk("t1_data", 64'(source_data), 64'(dat_t[k]));
        end
        $display("pass-through frame done");

        // ---- abort rewinds the write pointer, next frame intact
        drive(1'b1, 32'hB0, 1'b0, 1'b0);
        drive(1'b1, 32'hB1, 1'b0, 1'b0);
        drive(1'b1, 32'hB2, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("abort_valid", 64'(source_valid), 64'd0);
        end
        chk("abort_level", 64'(level), 64'd0);
        drive(1'b1, 32'hA0, 1'b0, 1'b0);
        chk("abort_rewind_addr0", 64'(sram_addr0), 64'd4);
        drive(1'b1, 32'hA1, 1'b1, 1'b0);
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hA1);
        drain(2, 0);
        $display("abort frame done");

        // ---- last and abort together: frame discarded
        drive(1'b1, 32'hC0, 1'b0, 1'b0);
        drive(1'b1, 32'hC1, 1'b0, 1'b0);
        drive(1'b1, 32'hC2, 1'b1, 1'b1);
        chk("lastabort_csb0", 64'(sram_csb0), 64'd1);
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("lastabort_valid", 64'(source_valid), 64'd0);
        end
        chk("lastabort_level", 64'(level), 64'd0);
        drive(1'b1, 32'hD0, 1'b1, 1'b0);
        chk("lastabort_rewind_addr0", 64'(sram_addr0), 64'd6);
        exp_q.push_back(32'hD0);
        drain(1, 0);
        $display("last+abort done");

        // ---- backpressure: 50-word frame drained with toggling ready
        for (int j = 0; j < 50; j++) begin
            drive(1'b1, 32'h500 + 32'(j), (j == 49), 1'b0);
            exp_q.push_back(32'h500 + 32'(j));
        end
        drain(50, 1);
        $display("backpressure frame done");

        // ---- overflow: 380 committed, 10-word frame dropped
        source_ready = 1'b0;
        for (int j = 0; j < 380; j++) begin
            drive(1'b1, 32'(j), (j == 379), 1'b0);
            exp_q.push_back(32'(j));
        end
        repeat (5) idle();
        chk("ovf_level_before", 64'(level), 64'd380);
        chk("ovf_valid_before", 64'(source_valid), 64'd1);
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 32'h1000 + 32'(j), (j == 9), 1'b0);
            chk("ovf_pulse", 64'(ovf_drop), 64'(j == 9));
            if (j == 5) chk("ovf_last_accept_csb0", 64'(sram_csb0), 64'd0);
            if (j == 6) chk("ovf_full_csb0", 64'(sram_csb0), 64'd1);
        end
        idle();
        chk("ovf_pulse_end", 64'(ovf_drop), 64'd0);
        chk("ovf_level_after", 64'(level), 64'd380);
        drain(380, 0);
        $display("overflow drop done");

        // ---- reset mid-frame discards committed and pending data
        source_ready = 1'b0;
        drive(1'b1, 32'hE0, 1'b0, 1'b0);
        drive(1'b1, 32'hE1, 1'b0, 1'b0);
        drive(1'b1, 32'hE2, 1'b1, 1'b0);
        repeat (4) idle();
        chk("midrst_valid_before", 64'(source_valid), 64'd1);
        drive(1'b1, 32'hF0, 1'b0, 1'b0);
        drive(1'b1, 32'hF1, 1'b0, 1'b0);
        @(posedge sys_clk);
        #1;
        sys_rst    = 1'b1;
        sink_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(source_valid), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_addr0", 64'(sram_addr0), 64'd0);
        repeat (3) idle();
        chk("midrst_valid_later", 64'(source_valid), 64'd0);
        $display("mid-frame reset done");

        // ---- wrap-around: 1000 single-word frames with random ready
        i_w = 0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(posedge sys_clk);
            #1;
            source_ready = 1'($urandom_range(0, 1));
            wr_now = (i_w < 1000) && (level < 300);
            sink_valid = wr_now;
            sink_data  = 32'(i_w);
            sink_last  = 1'b1;
            sink_abort = 1'b0;
            if (wr_now) exp_q.push_back(32'(i_w));
            #1;
            cyc++;
            if (wr_now && i_w == 383) chk("wrap_addr0_top", 64'(sram_addr0), 64'd383);
            if (wr_now && i_w == 384) chk("wrap_addr0_zero", 64'(sram_addr0), 64'd0);
            if (wr_now) i_w++;
            if (source_valid && source_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                chk("wrap_data", 64'(source_data), 64'(e));
                got++;
            end
        end
        chk("wrap_count", 64'(got), 64'd1000);
        source_ready = 1'b1;
        repeat (3) idle();
        chk("wrap_empty_valid", 64'(source_valid), 64'd0);
        $display("wrap-around stream done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
